// File: rtl/nios_pio_in_edge.sv
// Avalon-MM input PIO: synchronise, optionally debounce and edge-detect WIDTH inputs,
// exposing data, irqmask and sticky edgecapture registers plus a level IRQ.
module nios_pio_in_edge #(
    parameter int              WIDTH           = 4,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 0,
    parameter int              EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] INPUT_IDLE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] clear_mask;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= INPUT_IDLE;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign stable = sync;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0]    cnt_q [WIDTH];
            logic [WIDTH-1:0] stable_q;

            // A new level is accepted on the clock where it has been seen DEBOUNCE_CYCLES times in a row.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable_q <= INPUT_IDLE;
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync[i] == stable_q[i]) begin
                            cnt_q[i] <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            stable_q[i] <= sync[i];
                            cnt_q[i]    <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CW'(1);
                        end
                    end
                end
            end

            assign stable = stable_q;
        end
    endgenerate

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = stable & ~prev_q;
            1:       edge_det = ~stable & prev_q;
            default: edge_det = stable ^ prev_q;
        endcase
    end

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        irqmask_d  = irqmask_q;
        clear_mask = '0;
        if (wr_en && address == 2'd2) irqmask_d = writedata[WIDTH-1:0];
        if (wr_en && address == 2'd3) clear_mask = writedata[WIDTH-1:0];
        // New edges override a simultaneous clear so no event is lost.
        edgecap_d = (edgecap_q & ~clear_mask) | edge_det;

        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = 32'(stable);
            2'd2:    readdata_d = 32'(irqmask_q);
            2'd3:    readdata_d = 32'(edgecap_q);
            default: readdata_d = '0;
        endcase

        irq_d = |(edgecap_q & irqmask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= INPUT_IDLE;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= stable;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios_pio_in_edge.sv
// Directed bench for nios_pio_in_edge: four instances (default, debounced, falling, any-edge)
// share one bus; each has its own inputs and outputs.
module tb_nios_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in0, in_db, in_f, in_a;
    logic [31:0] rd0, rd_db, rd_f, rd_a;
    logic        irq0, irq_db, irq_f, irq_a;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios_pio_in_edge u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

    nios_pio_in_edge #(.DEBOUNCE_CYCLES(4)) u_dut_db (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_db), .readdata(rd_db), .irq(irq_db));

    nios_pio_in_edge #(.EDGE_TYPE(1)) u_dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_f), .readdata(rd_f), .irq(irq_f));

    nios_pio_in_edge #(.EDGE_TYPE(2)) u_dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        address    = 2'd0;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        in0 = '0; in_db = '0; in_f = '0; in_a = '0;

        // reset and idle
        tick(3);
        chk("rst_readdata", rd0, 32'h0);
        chk("rst_irq", {31'b0, irq0}, 32'h0);
        chk("rst_irq_db", {31'b0, irq_db}, 32'h0);
        reset_n = 1'b1;
        tick(3);
        chk("idle_data", rd0, 32'h0);

        // synchronised read and capture latency (SYNC_STAGES=2, no debounce)
        in0 = 4'b1010;
        tick(2);
        chk("data_e2", rd0, 32'h0);
        address = 2'd3;
        tick(1);
        chk("ecap_e3_pre", rd0, 32'h0);
        tick(1);
        chk("ecap_e4", rd0, 32'hA);
        address = 2'd0;
        tick(1);
        chk("data_A", rd0, 32'hA);
        chk("irq_masked", {31'b0, irq0}, 32'h0);

        bus_wr(2'd3, 32'hF);
        address = 2'd3;
        tick(1);
        chk("ecap_cleared", rd0, 32'h0);

        // irqmask readback, upper bits dropped; reserved address
        bus_wr(2'd2, 32'hFFFF_FFF2);
        address = 2'd2;
        tick(1);
        chk("mask_rb", rd0, 32'h2);
        address = 2'd1;
        tick(1);
        chk("reserved", rd0, 32'h0);
        address = 2'd0;

        // interrupt path on bit 1
        in0 = 4'b1000;
        tick(4);
        in0 = 4'b1010;
        tick(2);
        chk("irq_e2", {31'b0, irq0}, 32'h0);
        tick(1);
        chk("irq_e3", {31'b0, irq0}, 32'h0);
        tick(1);
        chk("irq_e4", {31'b0, irq0}, 32'h1);
        bus_wr(2'd3, 32'h2);
        chk("irq_clr_cycle", {31'b0, irq0}, 32'h1);
        tick(1);
        chk("irq_clr_next", {31'b0, irq0}, 32'h0);
        address = 2'd3;
        tick(1);
        chk("ecap_after_clr", rd0, 32'h0);
        address = 2'd0;

        // masked bit 3 capture, then enabling it through the mask
        in0 = 4'b0010;
        tick(4);
        in0 = 4'b1010;
        tick(5);
        chk("irq_gated", {31'b0, irq0}, 32'h0);
        address = 2'd3;
        tick(1);
        chk("ecap_bit3", rd0, 32'h8);
        bus_wr(2'd2, 32'hA);
        chk("irq_mask_cycle", {31'b0, irq0}, 32'h0);
        tick(1);
        chk("irq_mask_next", {31'b0, irq0}, 32'h1);
        bus_wr(2'd3, 32'hF);
        bus_wr(2'd2, 32'h1);
        tick(2);
        chk("irq_off", {31'b0, irq0}, 32'h0);

        // debounce: 3-cycle glitches never accepted with DEBOUNCE_CYCLES=4
        for (int g = 0; g < 3; g++) begin
            in_db = 4'b0001;
            tick(3);
            in_db = 4'b0000;
            tick(3);
        end
        tick(4);
        chk("db_glitch_data", rd_db, 32'h0);
        address = 2'd3;
        tick(1);
        chk("db_glitch_ecap", rd_db, 32'h0);
        chk("db_glitch_irq", {31'b0, irq_db}, 32'h0);
        in_db = 4'b0001;
        tick(7);
        chk("db_ecap_e7_pre", rd_db, 32'h0);
        chk("db_irq_e7", {31'b0, irq_db}, 32'h0);
        tick(1);
        chk("db_ecap_e8", rd_db, 32'h1);
        chk("db_irq_e8", {31'b0, irq_db}, 32'h1);
        address = 2'd0;
        tick(1);
        chk("db_data", rd_db, 32'h1);

        // set-vs-clear collision on bit 2, then read during a clear
        bus_wr(2'd3, 32'hF);
        in0 = 4'b1110;
        tick(2);
        bus_wr(2'd3, 32'h4);
        address = 2'd3;
        tick(1);
        chk("collide_set_wins", rd0, 32'h4);
        bus_wr(2'd3, 32'h4);
        chk("read_pre_clear", rd0, 32'h4);
        address = 2'd3;
        tick(1);
        chk("read_post_clear", rd0, 32'h0);

        // falling-edge instance
        bus_wr(2'd3, 32'hF);
        address = 2'd3;
        in_f = 4'b0001;
        tick(6);
        chk("fall_rise_ignored", rd_f, 32'h0);
        in_f = 4'b0000;
        tick(6);
        chk("fall_captured", rd_f, 32'h1);

        // any-edge instance, clearing between the two edges
        bus_wr(2'd3, 32'hF);
        address = 2'd3;
        in_a = 4'b0001;
        tick(6);
        chk("any_rise", rd_a, 32'h1);
        bus_wr(2'd3, 32'h1);
        address = 2'd3;
        tick(1);
        chk("any_cleared", rd_a, 32'h0);
        in_a = 4'b0000;
        tick(6);
        chk("any_fall", rd_a, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
